// File: rtl/irq_ctrl.sv
// Interrupt controller for the CSR unit: synchronises the CLINT/PLIC lines,
// evaluates the Sstc supervisor timer compare, builds mip_next and arbitrates
// pending interrupts into a single valid/ack trap request towards the core.
module irq_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clint_msip,
    input  logic        clint_mtip,
    input  logic        plic_meip,
    input  logic        plic_seip,
    input  logic [63:0] timer_counter,
    input  logic [31:0] stimecmp,
    input  logic [31:0] stimecmph,
    input  logic [31:0] menvcfgh,
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic [31:0] mideleg,
    input  logic [31:0] mstatus,
    input  logic [1:0]  privilege_mode,
    output logic [31:0] mip_next,
    output logic        irq_valid,
    output logic [31:0] irq_cause,
    input  logic        irq_ack,
    output logic        wfi_wakeup
);

    localparam int          CNT_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [1:0]  PRIV_U   = 2'd0;
    localparam logic [1:0]  PRIV_S   = 2'd1;
    localparam logic [1:0]  PRIV_M   = 2'd3;
    // Interrupt codes this block can raise: 11, 9, 7, 5, 3, 1.
    localparam logic [31:0] IRQ_MASK = 32'h0000_0AAA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Line order in the synchroniser: 0=msip, 1=mtip, 2=meip, 3=seip.
    logic [3:0]                   irq_in;
    logic [3:0][SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                         msip_s, mtip_s, meip_s, seip_s;
    logic                         stip_q, stip_d;

    logic [31:0]                  pend;
    logic [31:0]                  elig;
    logic                         m_glob, s_glob;
    logic                         sel_valid;
    logic [3:0]                   sel_code;
    logic                         latched_elig;

    state_t                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         irq_valid_q;
    logic [31:0]                  irq_cause_q;

    logic                         unused_ok;

    assign irq_in = {plic_seip, plic_meip, clint_mtip, clint_msip};
    assign msip_s = sync_q[0][SYNC_STAGES-1];
    assign mtip_s = sync_q[1][SYNC_STAGES-1];
    assign meip_s = sync_q[2][SYNC_STAGES-1];
    assign seip_s = sync_q[3][SYNC_STAGES-1];

    // Shift each async line one stage deeper; compare mtime against stimecmp.
    always_comb begin
        sync_d = sync_q;
        for (int i = 0; i < 4; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], irq_in[i]};
        end
        // A wrapped counter simply reads as not-yet-reached.
        stip_d = ({stimecmph, stimecmp} <= timer_counter);
    end

    // Synchroniser chains and the registered supervisor timer compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            stip_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            stip_q <= stip_d;
        end
    end

    // Next mip: hardware-owned bits from the pins, STIP from Sstc, SSIP kept.
    always_comb begin
        mip_next     = '0;
        mip_next[11] = meip_s;
        mip_next[9]  = seip_s;
        mip_next[7]  = mtip_s;
        mip_next[3]  = msip_s;
        mip_next[5]  = menvcfgh[31] ? stip_q : mip[5];
        mip_next[1]  = mip[1];
    end

    // Eligibility per code and fixed-priority selection of the winner.
    always_comb begin
        pend   = mip & mie;
        m_glob = (privilege_mode != PRIV_M) || mstatus[3];
        s_glob = (privilege_mode == PRIV_U) ||
                 ((privilege_mode == PRIV_S) && mstatus[1]);
        elig   = pend & IRQ_MASK &
                 ((~mideleg & {32{m_glob}}) | (mideleg & {32{s_glob}}));

        sel_valid = 1'b1;
        if (elig[11])      sel_code = 4'd11;
        else if (elig[3])  sel_code = 4'd3;
        else if (elig[7])  sel_code = 4'd7;
        else if (elig[9])  sel_code = 4'd9;
        else if (elig[1])  sel_code = 4'd1;
        else if (elig[5])  sel_code = 4'd5;
        else begin
            sel_valid = 1'b0;
            sel_code  = 4'd0;
        end

        latched_elig = elig[irq_cause_q[4:0]];
    end

    // Request FSM: raise, hold until ack or withdrawal, then a short holdoff.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            irq_valid_q <= 1'b0;
            irq_cause_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state_q     <= ST_REQ;
                        irq_valid_q <= 1'b1;
                        irq_cause_q <= {1'b1, 27'b0, sel_code};
                    end
                end
                ST_REQ: begin
                    // Ack wins over a simultaneous loss of eligibility.
                    if (irq_ack) begin
                        state_q     <= ST_HOLD;
                        irq_valid_q <= 1'b0;
                        cnt_q       <= CNT_W'(HOLDOFF_CYCLES);
                    end else if (!latched_elig) begin
                        state_q     <= ST_IDLE;
                        irq_valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Gives the trap's mstatus/privilege update time to land.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    irq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid  = irq_valid_q;
    assign irq_cause  = irq_cause_q;
    assign wfi_wakeup = |(mip & mie);

    assign unused_ok = ^{menvcfgh[30:0], mstatus[31:4], mstatus[2], mstatus[0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl. Models the CSR unit's mip register
// (mip <= mip_next, with optional software writes) and a free-running mtime.
`timescale 1ns/1ps
module tb_irq_ctrl;

    localparam int SYNC_STAGES    = 2;
    localparam int HOLDOFF_CYCLES = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        clint_msip, clint_mtip, plic_meip, plic_seip;
    logic [63:0] timer_counter = 64'h0000_0001_FFFF_FFF0;
    logic [31:0] stimecmp, stimecmph, menvcfgh;
    logic [31:0] mip, mie, mideleg, mstatus;
    logic [1:0]  privilege_mode;
    logic [31:0] mip_next;
    logic        irq_valid;
    logic [31:0] irq_cause;
    logic        irq_ack;
    logic        wfi_wakeup;

    logic        sw_wr;
    logic [31:0] sw_val;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    irq_ctrl #(
        .SYNC_STAGES   (SYNC_STAGES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .clint_msip    (clint_msip),
        .clint_mtip    (clint_mtip),
        .plic_meip     (plic_meip),
        .plic_seip     (plic_seip),
        .timer_counter (timer_counter),
        .stimecmp      (stimecmp),
        .stimecmph     (stimecmph),
        .menvcfgh      (menvcfgh),
        .mip           (mip),
        .mie           (mie),
        .mideleg       (mideleg),
        .mstatus       (mstatus),
        .privilege_mode(privilege_mode),
        .mip_next      (mip_next),
        .irq_valid     (irq_valid),
        .irq_cause     (irq_cause),
        .irq_ack       (irq_ack),
        .wfi_wakeup    (wfi_wakeup)
    );

    always #5 clk = ~clk;

    // CSR unit model: mip registers mip_next unless software writes it.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)    mip <= '0;
        else if (sw_wr) mip <= sw_val;
        else            mip <= mip_next;
    end

    always @(posedge clk) timer_counter <= timer_counter + 64'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cmp(input logic [63:0] v);
        {stimecmph, stimecmp} = v;
    endtask

    // Waits up to bound falling edges for irq_valid; n=-1 on timeout.
    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (irq_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic quiet();
        clint_msip = 0; clint_mtip = 0; plic_meip = 0; plic_seip = 0;
        mie = '0; mideleg = '0; menvcfgh = '0; irq_ack = 0;
        set_cmp('1);
        @(negedge clk);
        sw_wr = 1; sw_val = '0;
        @(negedge clk);
        sw_wr = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clint_msip = i[0]; clint_mtip = ~i[0]; plic_meip = i[1]; plic_seip = ~i[1];
        end
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", irq_valid);
        end
        checks++;
        if (irq_cause !== 32'h0) begin
            errors++; $display("FAIL reset_cause: got %h expected 00000000", irq_cause);
        end
        checks++;
        if ((mip_next & 32'h0000_0A88) !== 32'h0) begin
            errors++; $display("FAIL reset_hw_bits: got %h expected 0", mip_next & 32'h0000_0A88);
        end
        checks++;
        if (mip_next !== (mip & 32'h0000_0022)) begin
            errors++; $display("FAIL reset_mip_next: got %h expected %h", mip_next, mip & 32'h22);
        end
        clint_msip = 0; clint_mtip = 0; plic_meip = 0; plic_seip = 0;
        @(negedge clk);
        resetn = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mti();
        int n;
        logic [31:0] exp;
        privilege_mode = 2'd3; mstatus = 32'h8; mie = 32'h80; mideleg = '0;
        clint_mtip = 1;
        exp_q.push_back(32'h8000_0007);
        @(negedge clk);
        checks++;
        if (mip_next[7] !== 1'b0) begin
            errors++; $display("FAIL mti_sync_early: got %b expected 0", mip_next[7]);
        end
        @(negedge clk);
        checks++;
        if (mip_next[7] !== 1'b1) begin
            errors++; $display("FAIL mti_mip_next: got %b expected 1", mip_next[7]);
        end
        wait_valid(10, n);
        checks++;
        if (n + 2 !== 4) begin
            errors++; $display("FAIL mti_latency: got edge %0d expected edge 4", n + 2);
        end
        exp = exp_q.pop_front();
        checks++;
        if (irq_cause !== exp) begin
            errors++; $display("FAIL mti_cause: got %h expected %h", irq_cause, exp);
        end
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b1 || irq_cause !== exp) begin
            errors++; $display("FAIL mti_stable: got valid %b cause %h expected 1 %h", irq_valid, irq_cause, exp);
        end
        irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
        for (int i = 0; i < HOLDOFF_CYCLES; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (irq_valid !== 1'b0) begin
                errors++; $display("FAIL mti_holdoff: cycle %0d got valid %b expected 0", i, irq_valid);
            end
        end
        exp_q.push_back(32'h8000_0007);
        wait_valid(8, n);
        exp = exp_q.pop_front();
        checks++;
        if (n < 0 || irq_cause !== exp) begin
            errors++; $display("FAIL mti_reraise: got n=%0d cause %h expected %h", n, irq_cause, exp);
        end
        quiet();
    endtask

    task automatic test_priority();
        int n;
        logic [31:0] exp;
        privilege_mode = 2'd3; mstatus = 32'h8; mie = 32'hAAA; mideleg = '0;
        plic_meip = 1; clint_mtip = 1;
        exp_q.push_back(32'h8000_000B);
        wait_valid(10, n);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL prio_latency: got %0d expected 4", n);
        end
        exp = exp_q.pop_front();
        checks++;
        if (irq_cause !== exp) begin
            errors++; $display("FAIL prio_cause: got %h expected %h", irq_cause, exp);
        end
        irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
        exp_q.push_back(32'h8000_000B);
        wait_valid(10, n);
        checks++;
        if (n <= HOLDOFF_CYCLES) begin
            errors++; $display("FAIL prio_holdoff: got reraise after %0d expected more than %0d", n, HOLDOFF_CYCLES);
        end
        exp = exp_q.pop_front();
        checks++;
        if (irq_cause !== exp) begin
            errors++; $display("FAIL prio_cause_again: got %h expected %h", irq_cause, exp);
        end
        quiet();
    endtask

    task automatic test_sstc();
        int n;
        int seen;
        logic [31:0] exp;
        menvcfgh = 32'h8000_0000; mideleg = 32'h20; mie = 32'h20;
        privilege_mode = 2'd1; mstatus = 32'h2;
        set_cmp(timer_counter + 64'd5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (mip_next[5] !== 1'b0) begin
                    errors++; $display("FAIL sstc_at_match: got %b expected 0", mip_next[5]);
                end
            end
        end
        checks++;
        if (mip_next[5] !== 1'b1) begin
            errors++; $display("FAIL sstc_after_match: got %b expected 1", mip_next[5]);
        end
        exp_q.push_back(32'h8000_0005);
        wait_valid(6, n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL sstc_latency: got %0d expected 2", n);
        end
        exp = exp_q.pop_front();
        checks++;
        if (irq_cause !== exp) begin
            errors++; $display("FAIL sstc_cause: got %h expected %h", irq_cause, exp);
        end
        privilege_mode = 2'd3; mstatus = 32'h8; irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (irq_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL sstc_mmode_valid: got %0d valid cycles expected 0", seen);
        end
        checks++;
        if (wfi_wakeup !== 1'b1) begin
            errors++; $display("FAIL sstc_wfi: got %b expected 1", wfi_wakeup);
        end
        quiet();
    endtask

    task automatic test_withdraw();
        int n;
        logic [31:0] exp;
        privilege_mode = 2'd3; mstatus = 32'h8; mie = 32'h80;
        clint_mtip = 1;
        exp_q.push_back(32'h8000_0007);
        wait_valid(10, n);
        exp = exp_q.pop_front();
        checks++;
        if (n < 0 || irq_cause !== exp) begin
            errors++; $display("FAIL wd_first: got n=%0d cause %h expected %h", n, irq_cause, exp);
        end
        mie = 32'h0;
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++; $display("FAIL wd_drop: got %b expected 0", irq_valid);
        end
        mie = 32'h80;
        exp_q.push_back(32'h8000_0007);
        wait_valid(5, n);
        checks++;
        if (n !== 1) begin
            errors++; $display("FAIL wd_idle: got re-request after %0d expected 1", n);
        end
        exp = exp_q.pop_front();
        checks++;
        if (irq_cause !== exp) begin
            errors++; $display("FAIL wd_cause: got %h expected %h", irq_cause, exp);
        end
        quiet();
    endtask

    task automatic test_sw_mip();
        menvcfgh = '0; mie = '0;
        sw_wr = 1; sw_val = 32'h20;
        @(negedge clk);
        sw_wr = 0;
        checks++;
        if (mip_next[5] !== 1'b1) begin
            errors++; $display("FAIL sw_stip: got %b expected 1", mip_next[5]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (mip_next[5] !== 1'b1) begin
            errors++; $display("FAIL sw_stip_hold: got %b expected 1", mip_next[5]);
        end
        sw_wr = 1; sw_val = 32'h82;
        @(negedge clk);
        sw_wr = 0;
        checks++;
        if (mip_next[7] !== 1'b0) begin
            errors++; $display("FAIL sw_mtip_lost: got %b expected 0", mip_next[7]);
        end
        checks++;
        if (mip_next[1] !== 1'b1) begin
            errors++; $display("FAIL sw_ssip: got %b expected 1", mip_next[1]);
        end
        quiet();
    endtask

    task automatic test_async_reset();
        int n;
        logic [31:0] exp;
        privilege_mode = 2'd3; mstatus = 32'h8; mie = 32'h80;
        clint_mtip = 1;
        exp_q.push_back(32'h8000_0007);
        wait_valid(10, n);
        exp = exp_q.pop_front();
        checks++;
        if (n < 0 || irq_cause !== exp) begin
            errors++; $display("FAIL ar_req: got n=%0d cause %h expected %h", n, irq_cause, exp);
        end
        #2 resetn = 0;
        #1;
        checks++;
        if (irq_valid !== 1'b0 || irq_cause !== 32'h0) begin
            errors++; $display("FAIL ar_clear: got valid %b cause %h expected 0 00000000", irq_valid, irq_cause);
        end
        @(negedge clk);
        clint_mtip = 0; mie = '0;
        resetn = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clint_msip = 0; clint_mtip = 0; plic_meip = 0; plic_seip = 0;
        set_cmp('1);
        menvcfgh = '0; mie = '0; mideleg = '0; mstatus = '0;
        privilege_mode = 2'd3; irq_ack = 0; sw_wr = 0; sw_val = '0;

        test_reset();
        test_mti();
        test_priority();
        test_sstc();
        test_withdraw();
        test_sw_mip();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
